// File: rtl/mem_io_pkg.sv
// Shared constants for mem_io_unit: I/O region layout, register offsets and TIMER_CTRL bits.
package mem_io_pkg;

   localparam int unsigned IO_REGION_SIZE = 16;
   localparam int unsigned IO_OFF_WIDTH   = 4;

   localparam logic [IO_OFF_WIDTH-1:0] OFF_IN_BASE       = 4'd0;
   localparam logic [IO_OFF_WIDTH-1:0] OFF_OUT_BASE      = 4'd4;
   localparam logic [IO_OFF_WIDTH-1:0] OFF_TIMER_COUNT   = 4'd8;
   localparam logic [IO_OFF_WIDTH-1:0] OFF_TIMER_COMPARE = 4'd9;
   localparam logic [IO_OFF_WIDTH-1:0] OFF_TIMER_CTRL    = 4'd10;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_IRQ_BIT = 1;

   typedef enum logic {
      SrcRam,
      SrcIo
   } rd_src_e;

   // First word address of the I/O region; also the RAM depth.
   function automatic int unsigned io_base(input int unsigned addr_width);
      return (32'd1 << addr_width) - IO_REGION_SIZE;
   endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port RAM with synchronous read; a same-cycle read returns the pre-write word.
module sync_ram #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1008
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_io_unit.sv
// Word-addressed RAM with a 16-word memory-mapped I/O window at the top of the address space.
// Optional timer/compare/irq block is built only when MEM_IO_TIMER_EN is defined.
module mem_io_unit
   import mem_io_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_IN     = 2,
   parameter int unsigned NUM_OUT    = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [ADDR_WIDTH-1:0]               addr,
   input  logic [DATA_WIDTH-1:0]               wr_data,
   input  logic                                wr_en,
   input  logic                                rd_en,
   input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   in_data,
   input  logic [NUM_IN-1:0]                   in_load,
   output logic [DATA_WIDTH-1:0]               rd_data,
   output logic                                rd_valid,
   output logic [NUM_OUT-1:0][DATA_WIDTH-1:0]  out_port,
   output logic                                irq
);

   localparam int unsigned RamDepth = io_base(ADDR_WIDTH);

   if (NUM_IN < 1 || NUM_IN > 4) begin : g_bad_num_in
      $error("NUM_IN must be in 1..4");
   end
   if (NUM_OUT < 1 || NUM_OUT > 4) begin : g_bad_num_out
      $error("NUM_OUT must be in 1..4");
   end

   // Address decode: the I/O window is where all bits above the offset are ones.
   logic                    is_io;
   logic [IO_OFF_WIDTH-1:0] offset;
   logic                    wr_io;

   assign is_io  = &addr[ADDR_WIDTH-1:IO_OFF_WIDTH];
   assign offset = addr[IO_OFF_WIDTH-1:0];
   assign wr_io  = wr_en & is_io;

   logic                  ram_we;
   logic                  ram_re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign ram_we = wr_en & ~is_io;
   assign ram_re = rd_en & ~is_io;

   sync_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RamDepth)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (addr),
      .wdata_i (wr_data),
      .rdata_o (ram_rdata)
   );

   // Input capture and output port registers.
   logic [NUM_IN-1:0][DATA_WIDTH-1:0]  in_q, in_d;
   logic [NUM_OUT-1:0][DATA_WIDTH-1:0] out_q, out_d;

   always_comb begin
      in_d = in_q;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (in_load[i]) begin
            in_d[i] = in_data[i];
         end
      end
   end

   always_comb begin
      out_d = out_q;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         if (wr_io && offset == 4'(OFF_OUT_BASE + i)) begin
            out_d[i] = wr_data;
         end
      end
   end

   assign out_port = out_q;

   // Timer view seen by the read mux; all zero when the timer is compiled out.
   logic [DATA_WIDTH-1:0] tmr_count;
   logic [DATA_WIDTH-1:0] tmr_compare;
   logic [DATA_WIDTH-1:0] tmr_ctrl;

`ifdef MEM_IO_TIMER_EN
   logic [DATA_WIDTH-1:0] tmr_count_q, tmr_count_d;
   logic [DATA_WIDTH-1:0] tmr_cmp_q, tmr_cmp_d;
   logic                  tmr_en_q, tmr_en_d;
   logic                  tmr_irq_q, tmr_irq_d;
   logic                  tmr_match;

   always_comb begin
      tmr_count_d = tmr_count_q;
      tmr_cmp_d   = tmr_cmp_q;
      tmr_en_d    = tmr_en_q;
      tmr_irq_d   = tmr_irq_q;
      tmr_match   = tmr_en_q && (tmr_count_q == tmr_cmp_q);

      if (wr_io && offset == OFF_TIMER_COUNT) begin
         tmr_count_d = wr_data;
      end else if (tmr_en_q) begin
         tmr_count_d = tmr_count_q + 1'b1;
      end

      if (wr_io && offset == OFF_TIMER_COMPARE) begin
         tmr_cmp_d = wr_data;
      end

      if (wr_io && offset == OFF_TIMER_CTRL) begin
         tmr_en_d = wr_data[CTRL_EN_BIT];
         if (wr_data[CTRL_IRQ_BIT]) begin
            tmr_irq_d = 1'b0;
         end
      end

      // A match in the same cycle as a clear keeps the flag set.
      if (tmr_match) begin
         tmr_irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_count_q <= '0;
         tmr_cmp_q   <= '0;
         tmr_en_q    <= 1'b0;
         tmr_irq_q   <= 1'b0;
      end else begin
         tmr_count_q <= tmr_count_d;
         tmr_cmp_q   <= tmr_cmp_d;
         tmr_en_q    <= tmr_en_d;
         tmr_irq_q   <= tmr_irq_d;
      end
   end

   always_comb begin
      tmr_ctrl               = '0;
      tmr_ctrl[CTRL_EN_BIT]  = tmr_en_q;
      tmr_ctrl[CTRL_IRQ_BIT] = tmr_irq_q;
   end

   assign tmr_count   = tmr_count_q;
   assign tmr_compare = tmr_cmp_q;
   assign irq         = tmr_irq_q;
`else
   assign tmr_count   = '0;
   assign tmr_compare = '0;
   assign tmr_ctrl    = '0;
   assign irq         = 1'b0;
`endif

   // I/O read mux, sampled in the read cycle so it reflects pre-write state.
   logic [DATA_WIDTH-1:0] io_rdata;

   always_comb begin
      io_rdata = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (offset == 4'(OFF_IN_BASE + i)) begin
            io_rdata = in_q[i];
         end
      end
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         if (offset == 4'(OFF_OUT_BASE + i)) begin
            io_rdata = out_q[i];
         end
      end
      case (offset)
         OFF_TIMER_COUNT:   io_rdata = tmr_count;
         OFF_TIMER_COMPARE: io_rdata = tmr_compare;
         OFF_TIMER_CTRL:    io_rdata = tmr_ctrl;
         default:           ;
      endcase
   end

   // Read response pipeline.
   logic                  rd_valid_q, rd_valid_d;
   rd_src_e               rd_src_q, rd_src_d;
   logic [DATA_WIDTH-1:0] io_rdata_q, io_rdata_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0] rd_cur;

   always_comb begin
      rd_valid_d = rd_en;
      rd_src_d   = rd_src_q;
      io_rdata_d = io_rdata_q;
      if (rd_en) begin
         rd_src_d   = is_io ? SrcIo : SrcRam;
         io_rdata_d = io_rdata;
      end
      rd_data_d = rd_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q       <= '0;
         out_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_src_q   <= SrcRam;
         io_rdata_q <= '0;
         rd_data_q  <= '0;
      end else begin
         in_q       <= in_d;
         out_q      <= out_d;
         rd_valid_q <= rd_valid_d;
         rd_src_q   <= rd_src_d;
         io_rdata_q <= io_rdata_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Gating with rst drops the response of a read issued just before reset.
   assign rd_cur   = (rd_src_q == SrcIo) ? io_rdata_q : ram_rdata;
   assign rd_valid = rd_valid_q & ~rst;
   assign rd_data  = rd_valid ? rd_cur : rd_data_q;

endmodule

// File: tb/tb_mem_io_unit.sv
// Scoreboard bench for mem_io_unit: directed scenarios plus random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mem_io_unit;

   localparam int unsigned AW      = 10;
   localparam int unsigned DW      = 32;
   localparam int unsigned NI      = 2;
   localparam int unsigned NO      = 1;
   localparam int unsigned IO_BASE = (1 << AW) - 16;
`ifdef MEM_IO_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic [AW-1:0]            addr;
   logic [DW-1:0]            wr_data;
   logic                     wr_en;
   logic                     rd_en;
   logic [NI-1:0][DW-1:0]    in_data;
   logic [NI-1:0]            in_load;
   logic [DW-1:0]            rd_data;
   logic                     rd_valid;
   logic [NO-1:0][DW-1:0]    out_port;
   logic                     irq;

   always #5 clk = ~clk;

   mem_io_unit #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_IN     (NI),
      .NUM_OUT    (NO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .in_data  (in_data),
      .in_load  (in_load),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .out_port (out_port),
      .irq      (irq)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state.
   logic [DW-1:0] ram_m [int];
   logic [DW-1:0] in_m  [NI];
   logic [DW-1:0] out_m [NO];
   logic [DW-1:0] cnt_m, cmp_m;
   bit            en_m, irq_m;

   logic [DW-1:0]         exp_q [$];
   logic                  exp_valid = 1'b0;
   logic [DW-1:0]         last_rd = '0;
   logic [DW-1:0]         mon_e;
   logic [NI-1:0][DW-1:0] din_cur = '0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input int unsigned a);
      int unsigned off;
      if (a < IO_BASE) return ram_m[a];
      off = a - IO_BASE;
      if (off < 4) return (off < NI) ? in_m[off] : '0;
      if (off < 8) return (off - 4 < NO) ? out_m[off - 4] : '0;
      if (TIMER) begin
         if (off == 8)  return cnt_m;
         if (off == 9)  return cmp_m;
         if (off == 10) return {{(DW-2){1'b0}}, irq_m, en_m};
      end
      return '0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NI; i++) in_m[i] = '0;
      for (int i = 0; i < NO; i++) out_m[i] = '0;
      cnt_m = '0;
      cmp_m = '0;
      en_m  = 1'b0;
      irq_m = 1'b0;
   endtask

   task automatic model_update(input bit wr, input int unsigned a, input logic [DW-1:0] d,
                               input logic [NI-1:0] ld, input logic [NI-1:0][DW-1:0] din);
      bit match;
      if (TIMER) begin
         match = en_m && (cnt_m == cmp_m);
         if (wr && a == IO_BASE + 8) cnt_m = d;
         else if (en_m) cnt_m = cnt_m + 1;
         if (wr && a == IO_BASE + 9) cmp_m = d;
         if (wr && a == IO_BASE + 10) begin
            en_m = d[0];
            if (d[1]) irq_m = 1'b0;
         end
         if (match) irq_m = 1'b1;
      end
      if (wr && a < IO_BASE) ram_m[a] = d;
      if (wr && a >= IO_BASE + 4 && a < IO_BASE + 4 + NO) out_m[a - IO_BASE - 4] = d;
      for (int i = 0; i < NI; i++) if (ld[i]) in_m[i] = din[i];
   endtask

   task automatic step(input bit rd, input bit wr, input int unsigned a, input logic [DW-1:0] d,
                       input logic [NI-1:0] ld);
      rd_en   = rd;
      wr_en   = wr;
      addr    = a[AW-1:0];
      wr_data = d;
      in_load = ld;
      in_data = din_cur;
      if (rd) exp_q.push_back(model_read(a));
      @(posedge clk);
      exp_valid = rd;
      model_update(wr, a, d, ld, din_cur);
      #1;
   endtask

   task automatic wr_t(input int unsigned a, input logic [DW-1:0] d);
      step(1'b0, 1'b1, a, d, '0);
   endtask

   task automatic rd_t(input int unsigned a);
      step(1'b1, 1'b0, a, '0, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, '0);
   endtask

   task automatic do_reset(input bit rd);
      rst     = 1'b1;
      rd_en   = rd;
      wr_en   = 1'b0;
      in_load = '0;
      @(posedge clk);
      exp_valid = 1'b0;
      model_clear();
      exp_q.delete();
      #1;
      rst     = 1'b0;
      rd_en   = 1'b0;
      last_rd = '0;
      check("reset_rd_valid", {31'b0, rd_valid}, '0);
      check("reset_rd_data", rd_data, '0);
      check("reset_out_port0", out_port[0], '0);
      check("reset_irq", {31'b0, irq}, '0);
   endtask

   // Monitor: compares every cycle, pops the scoreboard when a response appears.
   always @(negedge clk) begin
      if (rst) begin
         check("rd_valid_in_reset", {31'b0, rd_valid}, '0);
      end else begin
         check("rd_valid", {31'b0, rd_valid}, {31'b0, exp_valid});
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_rd_valid: got rd_data %h expected no response", rd_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("rd_data", rd_data, mon_e);
               last_rd = mon_e;
            end
         end else begin
            check("rd_hold", rd_data, last_rd);
         end
         check("irq", {31'b0, irq}, {31'b0, irq_m});
         for (int i = 0; i < NO; i++) check("out_port", out_port[i], out_m[i]);
      end
   end

   initial begin
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
      in_load = '0; in_data = '0;
      model_clear();
      do_reset(1'b0);

      for (int i = 0; i < 32; i++) wr_t(i, $urandom);

      // RAM round trip
      wr_t(32'h010, 32'hDEADBEEF);
      rd_t(32'h010);

      // Output port write, readback and reserved out offset
      wr_t(32'h3F4, 32'h5A);
      rd_t(32'h3F4);
      wr_t(32'h3F5, 32'h77);
      rd_t(32'h3F5);

      // Input capture then change without load
      din_cur[1] = 32'h1234;
      step(1'b0, 1'b0, 0, '0, 2'b10);
      din_cur[1] = 32'hFFFF;
      idle(1);
      rd_t(32'h3F1);
      rd_t(32'h3F2);
      rd_t(32'h3FF);

      // Read-before-write
      wr_t(5, 7);
      step(1'b1, 1'b1, 5, 9, '0);
      rd_t(5);

      // Timer: compare/irq, clear, clear colliding with a match, wrap
      wr_t(32'h3F9, 3);
      wr_t(32'h3FA, 1);
      idle(6);
      rd_t(32'h3FA);
      wr_t(32'h3FA, 3);
      idle(2);
      wr_t(32'h3FA, 0);
      wr_t(32'h3F8, 20);
      wr_t(32'h3F9, 20);
      wr_t(32'h3FA, 1);
      wr_t(32'h3FA, 3);
      idle(2);
      wr_t(32'h3F8, 32'hFFFF_FFFF);
      rd_t(32'h3F8);
      rd_t(32'h3F8);
      wr_t(32'h3FA, 2);
      rd_t(32'h3FA);

      // Reset mid-read, then a read issued during reset, then RAM retention
      rd_t(32'h010);
      do_reset(1'b1);
      idle(1);
      rd_t(32'h010);
      rd_t(5);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         int unsigned a;
         a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 31) : IO_BASE + $urandom_range(0, 15);
         for (int i = 0; i < NI; i++) din_cur[i] = $urandom;
         step(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 4), a, $urandom,
              NI'($urandom_range(0, (1 << NI) - 1)));
      end

      idle(3);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_io_unit.md
MEM_IO_UNIT -- requirements
Module: mem_io_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word-address width; RAM depth is 2**ADDR_WIDTH minus the top 16 words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of RAM, ports and timer.
REQ-003 SHALL have parameter NUM_IN, default 2, legal range 1..4: number of input ports.
REQ-004 SHALL have parameter NUM_OUT, default 1, legal range 1..4: number of output ports.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port addr, input, ADDR_WIDTH: word address.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH: write data.
REQ-010 SHALL have port wr_en, input, 1: write strobe.
REQ-011 SHALL have port rd_en, input, 1: read strobe.
REQ-012 SHALL have port in_data, input, NUM_IN x DATA_WIDTH: external input values, such as switches.
REQ-013 SHALL have port in_load, input, NUM_IN: per-port capture enable.
REQ-014 SHALL have port rd_data, output, DATA_WIDTH: registered read data.
REQ-015 SHALL have port rd_valid, output, 1: rd_data is valid this cycle.
REQ-016 SHALL have port out_port, output, NUM_OUT x DATA_WIDTH: output port registers.
REQ-017 SHALL have port irq, output, 1: timer compare interrupt; tied 0 when the timer is compiled out.

Function
REQ-018 SHALL define the I/O region as addresses at or above IO_BASE = 2**ADDR_WIDTH-16. Offsets:
- 0..3 = input port i
- 4..7 = output port i
- 8 = TIMER_COUNT
- 9 = TIMER_COMPARE
- 10 = TIMER_CTRL (bit0 enable, bit1 irq flag)
- others reserved
REQ-019 SHALL write RAM when wr_en=1 and addr < IO_BASE; I/O-region writes SHALL never modify RAM.
REQ-020 SHALL load out_port[i] from wr_data when wr_en=1 and addr = IO_BASE+4+i with i < NUM_OUT; writes to other out offsets SHALL be ignored.
REQ-021 SHALL capture in_data[i] into input register i on each cycle in_load[i]=1, independent of bus activity.
REQ-022 SHALL present read data one cycle after a cycle with rd_en=1: rd_data is driven and rd_valid=1 for exactly one cycle.
REQ-023 SHALL, for read sources:
- RAM word
- input register i
- out_port[i] readback
- timer registers
- 0 for reserved offsets or i >= NUM_IN/NUM_OUT
REQ-024 SHALL hold rd_data at its last value when rd_valid=0.
REQ-025 SHALL support back-to-back reads every cycle, giving one rd_valid per rd_en with no bubbles.
REQ-026 SHALL, when rd_en and wr_en are both high to the same address, return the pre-write value (read-before-write) and perform the write.
REQ-027 SHALL, when the timer enable bit is set, increment TIMER_COUNT by 1 per cycle, wrapping at all-ones to 0.
REQ-028 SHALL set the irq flag sticky in the cycle after TIMER_COUNT equals TIMER_COMPARE while enabled; irq SHALL equal the flag.
REQ-029 SHALL clear the irq flag by writing TIMER_CTRL with bit1=1; a simultaneous compare match SHALL win, leaving the flag set.
REQ-030 SHALL let a write to TIMER_COUNT override the increment in that cycle.

Reset
REQ-031 SHALL, while rst=1, clear rd_data, rd_valid, all out_port, all input registers, TIMER_COUNT, TIMER_COMPARE, TIMER_CTRL and irq to 0 at the clock edge.
REQ-032 SHALL leave RAM contents unaffected by reset.
REQ-033 SHALL suppress the rd_valid pulse for a read issued in the cycle before or during reset.

Configuration
REQ-034 SHALL implement the timer, compare and irq logic only when macro MEM_IO_TIMER_EN is defined.
REQ-035 SHALL, when MEM_IO_TIMER_EN is undefined, read offsets 8..10 as 0, ignore writes to them and tie irq to 0.

Structure
REQ-036 SHALL place IO region size (16), offset constants and the TIMER_CTRL bit positions in package mem_io_pkg.
REQ-037 SHALL use one sub-module, sync_ram: single-port, synchronous read, read-before-write, depth 2**ADDR_WIDTH-16.

Verification
REQ-038 SHALL cover RAM round-trip: write 0xDEADBEEF to addr 0x010, then read 0x010 -> rd_valid one cycle later, rd_data=0xDEADBEEF.
REQ-039 SHALL cover I/O isolation: write 0x5A to 0x3F4 (out_port[0]) -> out_port[0]=0x5A next cycle; RAM word at 0x3F4 is not written; readback of 0x3F4 returns 0x5A.
REQ-040 SHALL cover input capture: in_data[1]=0x1234 with in_load[1] pulsed, then changed to 0xFFFF without a load; read 0x3F1 -> 0x1234.
REQ-041 SHALL cover read-before-write: RAM[5]=7, same-cycle rd_en and wr_en to addr 5 with wr_data 9 -> rd_data=7; a following read -> 9.
REQ-042 SHALL cover the timer (MEM_IO_TIMER_EN): COMPARE=3, CTRL=1 -> irq rises after COUNT=3; write CTRL=0x3 -> irq clears unless a match occurs that cycle; COUNT preset to 0xFFFFFFFF wraps to 0.
REQ-043 SHALL cover reset mid-read: rd_en in cycle N, rst in cycle N+1 -> no rd_valid pulse; all outputs 0.
